// File: rtl/mux_scan_sequencer.sv
// Scans a 4-bit word through an external mux4to1, one channel per dwell period, and rebuilds the word from y_in.
// Frame takes 4*(hold+1)+1 cycles from transfer to in_ready; in_ready is low for the whole frame, nothing is buffered.
module mux_scan_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [3:0] hold,
  input  logic       abort,
  output logic [3:0] X,
  output logic [1:0] sel,
  input  logic       y_in,
  output logic       out_bit,
  output logic       out_valid,
  output logic [3:0] out_word,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] dwell;
  logic [3:0] hold_r;

  // Pure state decode so in_ready is already 1 while rst_n is held low.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      X          <= 4'd0;
      sel        <= 2'd0;
      dwell      <= 4'd0;
      hold_r     <= 4'd0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      out_word   <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            X        <= in_data;
            hold_r   <= hold;
            sel      <= 2'd0;
            dwell    <= 4'd0;
            out_word <= 4'd0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
            sel   <= 2'd0;
          end else if (dwell < hold_r) begin
            dwell <= dwell + 4'd1;
          end else begin
            // End of dwell: y_in has been stable for the whole period.
            out_bit       <= y_in;
            out_valid     <= 1'b1;
            out_word[sel] <= y_in;
            if (sel != 2'd3) begin
              sel   <= sel + 2'd1;
              dwell <= 4'd0;
            end else begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (abort) begin
            sel <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
